regfile_wb_arbiter: RTL

- Shares the single register-file write port (we/waddr/data) between two writeback requesters: A (ALU) and B (load/store unit).
- Each requester uses a valid/ready handshake.
- Round-robin or fixed-priority arbitration, with a starvation guard in fixed mode.
- Registered write output to the regfile; writes to r0 are discarded.

---
 rtl/regfile_wb_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between ALU (A) and LSU (B) writeback.
// Round-robin or fixed priority with a B starvation guard; registered write, r0 writes dropped.
module regfile_wb_arbiter #(
    parameter int WORD     = 32,
    parameter int RR       = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            a_valid,
    input  logic [4:0]      a_addr,
    input  logic [WORD-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_addr,
    input  logic [WORD-1:0] b_data,
    output logic            b_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [WORD-1:0] rf_wdata,
    output logic            last_b
);
    logic [3:0] wait_cnt;
    logic       force_b;
    logic       a_wr;
    logic       b_wr;

    assign force_b = (RR == 0) && (wait_cnt == 4'(MAX_WAIT));
    assign a_wr    = a_ready && (a_addr != 5'd0);
    assign b_wr    = b_ready && (b_addr != 5'd0);

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !hold) begin
            if (a_valid && b_valid) begin
                b_ready = (RR != 0) ? !last_b : force_b;
                a_ready = !b_ready;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
            last_b   <= 1'b1;
            wait_cnt <= 4'd0;
        end else begin
            rf_we <= a_wr || b_wr;
            if (a_wr) begin
                rf_waddr <= a_addr;
                rf_wdata <= a_data;
            end else if (b_wr) begin
                rf_waddr <= b_addr;
                rf_wdata <= b_data;
            end
            if (a_ready || b_ready)
                last_b <= b_ready;
            // Counter tracks consecutive refused-while-valid cycles of B; frozen during hold.
            if (RR != 0)
                wait_cnt <= 4'd0;
            else if (!hold) begin
                if (!b_valid || b_ready)
                    wait_cnt <= 4'd0;
                else if (wait_cnt < 4'(MAX_WAIT))
                    wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end
endmodule
